mpu_loader: RTL

- Upstream stage of mpu_dispatcher.
- Accepts a valid/ready stream of float_sp elements and writes two M x N operand matrices (A, then B) into the matrix register file, row-major.
- Once both matrices are written, it starts the dispatcher, waits for its ack and finish, then reports completion.
- Sits between the memory/stream front end and the register file + dispatcher.

---
 rtl/mpu_loader_pkg.sv | 31 +++
 rtl/mpu_loader_if.sv | 21 ++
 rtl/mpu_loader_index_counter.sv | 46 ++++
 rtl/mpu_loader.sv | 132 +++++++++++++
 4 files changed

// File: rtl/mpu_loader_pkg.sv
// Shared constants and types for the matrix operand loader.
// Matrix geometry, index widths and the loader state encoding live here.
package mpu_loader_pkg;

    localparam int M      = 3;
    localparam int N      = 3;
    localparam int MBITS  = 1;
    localparam int NBITS  = 1;
    localparam int DATA_W = 32;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [2:0] {
        LOAD_IDLE      = 3'd0,
        LOAD_A         = 3'd1,
        LOAD_B         = 3'd2,
        LOAD_DISPATCH  = 3'd3,
        LOAD_WAIT_DONE = 3'd4
    } load_state_e;

    typedef enum logic {
        MAT_A = 1'b0,
        MAT_B = 1'b1
    } matrix_sel_e;

    function automatic matrix_sel_e toggle_sel(input matrix_sel_e s);
        return (s == MAT_A) ? MAT_B : MAT_A;
    endfunction

endpackage

// File: rtl/mpu_loader_if.sv
// Valid/ready element stream feeding the loader.
// The front end drives through master; the loader consumes through slave.
interface mpu_loader_if;

    logic                                 mem_valid_in;
    logic                                 mem_ready_out;
    logic [mpu_loader_pkg::DATA_W-1:0]    mem_data_in;

    modport master (
        output mem_valid_in,
        output mem_data_in,
        input  mem_ready_out
    );

    modport slave (
        input  mem_valid_in,
        input  mem_data_in,
        output mem_ready_out
    );

endinterface

// File: rtl/mpu_loader_index_counter.sv
// Row-major (i, j) counter over a ROWS x COLS matrix.
// Advances only on i_adv; o_last flags the final element so the owner can switch matrices.
module mpu_loader_index_counter #(
    parameter int ROWS  = 3,
    parameter int COLS  = 3,
    parameter int IBITS = 1,
    parameter int JBITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_adv,
    output logic [IBITS:0]   o_i,
    output logic [JBITS:0]   o_j,
    output logic             o_last
);

    localparam logic [IBITS:0] I_LAST = (IBITS+1)'(ROWS - 1);
    localparam logic [JBITS:0] J_LAST = (JBITS+1)'(COLS - 1);

    logic [IBITS:0] r_i;
    logic [JBITS:0] r_j;

    // Index state: clear wins over advance; at the last column wrap j and bump i.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_i <= '0;
            r_j <= '0;
        end else if (i_clr) begin
            r_i <= '0;
            r_j <= '0;
        end else if (i_adv) begin
            if (r_j == J_LAST) begin
                r_j <= '0;
                r_i <= (r_i == I_LAST) ? '0 : r_i + (IBITS+1)'(1);
            end else begin
                r_j <= r_j + (JBITS+1)'(1);
            end
        end
    end

    assign o_i    = r_i;
    assign o_j    = r_j;
    assign o_last = (r_i == I_LAST) && (r_j == J_LAST);

endmodule

// File: rtl/mpu_loader.sv
// Streams two M x N operand matrices (A then B) into the register file,
// then kicks the dispatcher and reports completion when it finishes.
module mpu_loader
    import mpu_loader_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load_start_in,
    output logic                load_ack_out,
    output logic                load_done_out,
    mpu_loader_if.slave         mem,
    output logic                reg_load_en_out,
    output logic                reg_load_sel_out,
    output logic [MBITS:0]      reg_load_i_out,
    output logic [NBITS:0]      reg_load_j_out,
    output logic [DATA_W-1:0]   reg_load_data_out,
    output logic                disp_start_out,
    input  logic                disp_ack_in,
    input  logic                disp_finished_in
);

    load_state_e        r_state;
    matrix_sel_e        r_sel;
    logic               r_done;
    logic               r_wr_en;
    logic               r_wr_sel;
    logic [MBITS:0]     r_wr_i;
    logic [NBITS:0]     r_wr_j;
    logic [DATA_W-1:0]  r_wr_data;

    logic               w_ready;
    logic               w_accept;
    logic               w_clr;
    logic               w_last;
    logic [MBITS:0]     w_i;
    logic [NBITS:0]     w_j;

    assign w_ready  = (r_state == LOAD_A) || (r_state == LOAD_B);
    assign w_accept = mem.mem_valid_in & w_ready;
    assign w_clr    = (r_state == LOAD_IDLE) & load_start_in;

    mpu_loader_index_counter #(
        .ROWS  (M),
        .COLS  (N),
        .IBITS (MBITS),
        .JBITS (NBITS)
    ) u_index (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_adv  (w_accept),
        .o_i    (w_i),
        .o_j    (w_j),
        .o_last (w_last)
    );

    // Loader sequencing; the done pulse is raised on the edge that returns to idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= LOAD_IDLE;
            r_sel   <= MAT_A;
            r_done  <= FALSE;
        end else begin
            r_done <= FALSE;
            case (r_state)
                LOAD_IDLE: begin
                    if (load_start_in) begin
                        r_state <= LOAD_A;
                        r_sel   <= MAT_A;
                    end
                end
                LOAD_A: begin
                    if (w_accept && w_last) begin
                        r_state <= LOAD_B;
                        r_sel   <= toggle_sel(r_sel);
                    end
                end
                LOAD_B: begin
                    if (w_accept && w_last) begin
                        r_state <= LOAD_DISPATCH;
                        r_sel   <= toggle_sel(r_sel);
                    end
                end
                LOAD_DISPATCH: begin
                    if (disp_ack_in) begin
                        r_state <= LOAD_WAIT_DONE;
                    end
                end
                LOAD_WAIT_DONE: begin
                    if (disp_finished_in) begin
                        r_state <= LOAD_IDLE;
                        r_done  <= TRUE;
                    end
                end
                default: begin
                    r_state <= LOAD_IDLE;
                    r_sel   <= MAT_A;
                end
            endcase
        end
    end

    // Register-file write port: one cycle behind acceptance, fields hold between beats.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_en   <= FALSE;
            r_wr_sel  <= 1'b0;
            r_wr_i    <= '0;
            r_wr_j    <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_accept;
            if (w_accept) begin
                r_wr_sel  <= r_sel;
                r_wr_i    <= w_i;
                r_wr_j    <= w_j;
                r_wr_data <= mem.mem_data_in;
            end
        end
    end

    assign mem.mem_ready_out  = w_ready;
    assign load_ack_out       = (r_state != LOAD_IDLE);
    assign disp_start_out     = (r_state == LOAD_DISPATCH);
    assign load_done_out      = r_done;
    assign reg_load_en_out    = r_wr_en;
    assign reg_load_sel_out   = r_wr_sel;
    assign reg_load_i_out     = r_wr_i;
    assign reg_load_j_out     = r_wr_j;
    assign reg_load_data_out  = r_wr_data;

endmodule
